io_decoder_pipe: RTL and testbench
==================================

// Module: io_decoder_pipe
// PURPOSE
//  Parametrised, registered host-IO front end for the CIM chip. Decodes a chip-select/opcode/channel address
//  word into per-channel input-FIFO write strobes, output-FIFO read strobes, config-register writes and CIM
//  write strobes. Adds a pipelined output-FIFO read path with a valid flag, full/empty gating with sticky
//  error flags, and a programmable slow clock. Sits between the pad ring and the input/output FIFO banks.
// PARAMETERS
//  DATA_IN_WIDTH   36    host write-data width
//  DATA_OUT_WIDTH  32    output-FIFO read-data width; also d_reg width
//  ADDR_IN_WIDTH   14    host address width (>=12)
//  N_IN_CH         16    input-FIFO channels (power of 2, 2..16); ICW=$clog2(N_IN_CH)
//  N_OUT_CH        4     output-FIFO channels (power of 2, 2..16); OCW=$clog2(N_OUT_CH)
//  REG_ADDR        4     config-register address width
//  ADDR_CIM_WIDTH  9     CIM address width, taken from a_in[ADDR_CIM_WIDTH-1:0]
//  CHIP_ID         4'h0  value a_in[AW-1:AW-4] must match
//  CLKM_DIV        2     clkm period in clk cycles (even, >=2)
// PORTS
//  clk          in   1                    system clock
//  rst          in   1                    synchronous active-high reset
//  addr_valid   in   1                    a_in/data_in carry a transaction this cycle
//  a_in         in   ADDR_IN_WIDTH        host address word
//  data_in      in   DATA_IN_WIDTH        host write data
//  full_in      in   N_IN_CH              per-channel input-FIFO full
//  empty_out    in   N_OUT_CH             per-channel output-FIFO empty
//  rd_data_bus  in   N_OUT_CH*DATA_OUT_W  output-FIFO read data; lane k = bits [k*DOW +: DOW]
//  err_clr      in   1                    clears all sticky error flags
//  in_wr_en     out  N_IN_CH              one-hot input-FIFO write strobe
//  wr_data      out  DATA_IN_WIDTH        registered write data
//  out_rd_en    out  N_OUT_CH             one-hot output-FIFO read strobe
//  data_out     out  DATA_OUT_WIDTH       registered read data
//  data_out_vld out  1                    data_out valid, one-cycle pulse
//  reg_en       out  1                    config-register write strobe
//  a_reg        out  REG_ADDR             register address (0 when reg_en low)
//  d_reg        out  DATA_OUT_WIDTH       wr_data[DATA_OUT_WIDTH-1:0]
//  wrt          out  1                    CIM write strobe
//  a_cim        out  ADDR_CIM_WIDTH       registered CIM address
//  clkm         out  1                    divided clock
//  err_ovf      out  1                    sticky: write to full channel
//  err_unf      out  1                    sticky: read from empty channel
//  err_addr     out  1                    sticky: reserved opcode or channel >= N
// BEHAVIOUR
//  - Reset: every output 0, divider counter 0, read pipeline flushed. Any in-flight read is dropped.
//  - Field decode:
//    - chip = a_in[AW-1:AW-4]; op = a_in[AW-5:AW-7]
//    - in_ch = a_in[ICW-1:0]; out_ch = a_in[4+OCW-1:4]
//    - Op codes: 000 nop, 001 wrt, 010 fifo wr, 011 reg wr, 100 fifo rd, 111 fifo wr + fifo rd; 101/110 reserved.
//  - A transaction is accepted only when addr_valid=1 and chip==CHIP_ID. A chip mismatch is silently ignored (no error).
//  - Stage 1: on an accepted edge T, a_in, data_in, full_in and empty_out are captured.
//  - Strobes: in_wr_en, out_rd_en, reg_en, wrt, wr_data, a_cim and a_reg are valid during cycle T+1 only
//    (single-cycle pulses). Back-to-back transactions are allowed every cycle.
//  - Full/empty gating and errors, all evaluated on the values captured at T:
//    - full_in[in_ch]=1: write suppressed, err_ovf set.
//    - empty_out[out_ch]=1: read suppressed, err_unf set.
//    - Reserved op, or in_ch/out_ch >= N: nothing issued, err_addr set.
//    - For op 111, each half is gated independently.
//  - Read path:
//    - out_rd_en is high in T+1; the FIFO drives its lane in T+2.
//    - The lane is captured at end of T+2; data_out_vld pulses in T+3.
//    - data_out holds until the next valid read. Fixed latency: 3 cycles from accept to data.
//  - Error flags: err_clr clears the flags at the next edge; a new error in the same cycle wins (flag stays 1).
//  - clkm: toggles every CLKM_DIV/2 clk cycles; free-running, independent of transactions.
// TESTING
//  - Reset: hold rst 2 cycles, then release -> all outputs 0; clkm toggles every CLKM_DIV/2 cycles.
//  - Write: addr {CHIP_ID,010,in_ch=5}, data 36'h9_ABCD_1234, full_in=0 ->
//    in_wr_en=16'h0020 and wr_data=9ABCD1234 at T+1 only.
//  - Read: op 100, out_ch=2, lane2=32'hDEADBEEF ->
//    out_rd_en=4'b0100 at T+1; data_out=DEADBEEF with data_out_vld=1 at T+3.
//  - Gating: write ch3 with full_in[3]=1 -> no strobe, err_ovf=1.
//    Then err_clr together with a read of an empty channel -> err_ovf=0, err_unf=1.
//  - Mismatch/reserved: chip=4'h1 -> no activity, no error.
//    Op 101 -> no strobes, err_addr=1.
//  - Stress: op 111 every cycle for 8 cycles, then rst asserted mid-stream ->
//    8 writes and 8 vld pulses in order; reset drops the pending vld.

Source files
------------

// File: rtl/io_decoder_pipe.sv
// Host-IO front end for the CIM chip: decodes chip/opcode/channel address words into
// registered single-cycle strobes, gates FIFO accesses on full/empty with sticky error
// flags, runs a fixed-latency output-FIFO read pipeline and a free-running divided clock.
module io_decoder_pipe #(
  parameter int unsigned DATA_IN_WIDTH  = 36,
  parameter int unsigned DATA_OUT_WIDTH = 32,
  parameter int unsigned ADDR_IN_WIDTH  = 14,
  parameter int unsigned N_IN_CH        = 16,
  parameter int unsigned N_OUT_CH       = 4,
  parameter int unsigned REG_ADDR       = 4,
  parameter int unsigned ADDR_CIM_WIDTH = 9,
  parameter logic [3:0]  CHIP_ID        = 4'h0,
  parameter int unsigned CLKM_DIV       = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               addr_valid,
  input  logic [ADDR_IN_WIDTH-1:0]           a_in,
  input  logic [DATA_IN_WIDTH-1:0]           data_in,
  input  logic [N_IN_CH-1:0]                 full_in,
  input  logic [N_OUT_CH-1:0]                empty_out,
  input  logic [N_OUT_CH*DATA_OUT_WIDTH-1:0] rd_data_bus,
  input  logic                               err_clr,
  output logic [N_IN_CH-1:0]                 in_wr_en,
  output logic [DATA_IN_WIDTH-1:0]           wr_data,
  output logic [N_OUT_CH-1:0]                out_rd_en,
  output logic [DATA_OUT_WIDTH-1:0]          data_out,
  output logic                               data_out_vld,
  output logic                               reg_en,
  output logic [REG_ADDR-1:0]                a_reg,
  output logic [DATA_OUT_WIDTH-1:0]          d_reg,
  output logic                               wrt,
  output logic [ADDR_CIM_WIDTH-1:0]          a_cim,
  output logic                               clkm,
  output logic                               err_ovf,
  output logic                               err_unf,
  output logic                               err_addr
);

  localparam int unsigned AW   = ADDR_IN_WIDTH;
  localparam int unsigned ICW  = $clog2(N_IN_CH);
  localparam int unsigned OCW  = $clog2(N_OUT_CH);
  localparam int unsigned DOW  = DATA_OUT_WIDTH;
  localparam int unsigned HALF = CLKM_DIV / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_WRT  = 3'b001;
  localparam logic [2:0] OP_FWR  = 3'b010;
  localparam logic [2:0] OP_REG  = 3'b011;
  localparam logic [2:0] OP_FRD  = 3'b100;
  localparam logic [2:0] OP_WRRD = 3'b111;

  logic [3:0]     chip;
  logic [2:0]     op;
  logic [ICW-1:0] in_ch;
  logic [OCW-1:0] out_ch;
  logic           accept, do_wr, do_rd, in_ok, out_ok;
  logic           set_ovf, set_unf, set_addr;

  logic [N_IN_CH-1:0]        in_wr_en_d,  in_wr_en_q;
  logic [DATA_IN_WIDTH-1:0]  wr_data_d,   wr_data_q;
  logic [N_OUT_CH-1:0]       out_rd_en_d, out_rd_en_q;
  logic                      reg_en_d,    reg_en_q;
  logic [REG_ADDR-1:0]       a_reg_d,     a_reg_q;
  logic                      wrt_d,       wrt_q;
  logic [ADDR_CIM_WIDTH-1:0] a_cim_d,     a_cim_q;
  logic [OCW-1:0]            ch_p1_d,     ch_p1_q;
  logic                      rd_p2_d,     rd_p2_q;
  logic [OCW-1:0]            ch_p2_d,     ch_p2_q;
  logic [DOW-1:0]            data_out_d,  data_out_q;
  logic                      vld_d,       vld_q;
  logic                      err_ovf_d,   err_ovf_q;
  logic                      err_unf_d,   err_unf_q;
  logic                      err_addr_d,  err_addr_q;
  logic [CW-1:0]             cnt_d,       cnt_q;
  logic                      clkm_d,      clkm_q;

  assign chip   = a_in[AW-1 -: 4];
  assign op     = a_in[AW-5 -: 3];
  assign in_ch  = a_in[ICW-1:0];
  assign out_ch = a_in[4 +: OCW];
  assign accept = addr_valid && (chip == CHIP_ID);
  assign do_wr  = op[1];
  assign do_rd  = op[2];
  assign in_ok  = 32'(in_ch) < N_IN_CH;
  assign out_ok = 32'(out_ch) < N_OUT_CH;

  // Decode the incoming word straight into next-cycle strobes; gating uses this cycle's full/empty.
  always_comb begin
    in_wr_en_d  = '0;
    out_rd_en_d = '0;
    reg_en_d    = 1'b0;
    a_reg_d     = '0;
    wrt_d       = 1'b0;
    wr_data_d   = '0;
    a_cim_d     = '0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    set_addr    = 1'b0;
    if (accept) begin
      wr_data_d = data_in;
      a_cim_d   = a_in[ADDR_CIM_WIDTH-1:0];
      case (op)
        OP_NOP: ;
        OP_WRT: wrt_d = 1'b1;
        OP_REG: begin
          reg_en_d = 1'b1;
          a_reg_d  = a_in[REG_ADDR-1:0];
        end
        OP_FWR, OP_FRD, OP_WRRD: begin
          if ((do_wr && !in_ok) || (do_rd && !out_ok)) begin
            set_addr = 1'b1;
          end else begin
            // the two halves of a combined op are gated independently
            if (do_wr) begin
              if (full_in[in_ch]) set_ovf = 1'b1;
              else                in_wr_en_d[in_ch] = 1'b1;
            end
            if (do_rd) begin
              if (empty_out[out_ch]) set_unf = 1'b1;
              else                   out_rd_en_d[out_ch] = 1'b1;
            end
          end
        end
        default: set_addr = 1'b1;
      endcase
    end
  end

  // Read pipeline, sticky errors and clock divider next-state.
  always_comb begin
    ch_p1_d    = out_ch;
    rd_p2_d    = |out_rd_en_q;
    ch_p2_d    = ch_p1_q;
    vld_d      = rd_p2_q;
    data_out_d = rd_p2_q ? rd_data_bus[ch_p2_q*DOW +: DOW] : data_out_q;
    err_ovf_d  = (err_ovf_q  & ~err_clr) | set_ovf;
    err_unf_d  = (err_unf_q  & ~err_clr) | set_unf;
    err_addr_d = (err_addr_q & ~err_clr) | set_addr;
    if (cnt_q == CW'(HALF - 1)) begin
      cnt_d  = '0;
      clkm_d = ~clkm_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      clkm_d = clkm_q;
    end
  end

  // All state, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_en_q  <= '0;
      wr_data_q   <= '0;
      out_rd_en_q <= '0;
      reg_en_q    <= 1'b0;
      a_reg_q     <= '0;
      wrt_q       <= 1'b0;
      a_cim_q     <= '0;
      ch_p1_q     <= '0;
      rd_p2_q     <= 1'b0;
      ch_p2_q     <= '0;
      data_out_q  <= '0;
      vld_q       <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      cnt_q       <= '0;
      clkm_q      <= 1'b0;
    end else begin
      in_wr_en_q  <= in_wr_en_d;
      wr_data_q   <= wr_data_d;
      out_rd_en_q <= out_rd_en_d;
      reg_en_q    <= reg_en_d;
      a_reg_q     <= a_reg_d;
      wrt_q       <= wrt_d;
      a_cim_q     <= a_cim_d;
      ch_p1_q     <= ch_p1_d;
      rd_p2_q     <= rd_p2_d;
      ch_p2_q     <= ch_p2_d;
      data_out_q  <= data_out_d;
      vld_q       <= vld_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_addr_q  <= err_addr_d;
      cnt_q       <= cnt_d;
      clkm_q      <= clkm_d;
    end
  end

  assign in_wr_en     = in_wr_en_q;
  assign wr_data      = wr_data_q;
  assign out_rd_en    = out_rd_en_q;
  assign data_out     = data_out_q;
  assign data_out_vld = vld_q;
  assign reg_en       = reg_en_q;
  assign a_reg        = a_reg_q;
  assign d_reg        = wr_data_q[DOW-1:0];
  assign wrt          = wrt_q;
  assign a_cim        = a_cim_q;
  assign clkm         = clkm_q;
  assign err_ovf      = err_ovf_q;
  assign err_unf      = err_unf_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_io_decoder_pipe.sv
// Self-checking bench for io_decoder_pipe: per-cycle strobe/error model plus write and
// read scoreboards; a small FIFO model drives the read lane one cycle after out_rd_en.
module tb_io_decoder_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         addr_valid = 1'b0;
  logic [13:0]  a_in = '0;
  logic [35:0]  data_in = '0;
  logic [15:0]  full_in = '0;
  logic [3:0]   empty_out = '0;
  logic [127:0] rd_data_bus = '0;
  logic         err_clr = 1'b0;
  logic [15:0]  in_wr_en;
  logic [35:0]  wr_data;
  logic [3:0]   out_rd_en;
  logic [31:0]  data_out;
  logic         data_out_vld;
  logic         reg_en;
  logic [3:0]   a_reg;
  logic [31:0]  d_reg;
  logic         wrt;
  logic [8:0]   a_cim;
  logic         clkm;
  logic         err_ovf, err_unf, err_addr;

  io_decoder_pipe #(
    .DATA_IN_WIDTH (36),
    .DATA_OUT_WIDTH(32),
    .ADDR_IN_WIDTH (14),
    .N_IN_CH       (16),
    .N_OUT_CH      (4),
    .REG_ADDR      (4),
    .ADDR_CIM_WIDTH(9),
    .CHIP_ID       (4'h0),
    .CLKM_DIV      (2)
  ) dut (
    .clk(clk), .rst(rst), .addr_valid(addr_valid), .a_in(a_in), .data_in(data_in),
    .full_in(full_in), .empty_out(empty_out), .rd_data_bus(rd_data_bus), .err_clr(err_clr),
    .in_wr_en(in_wr_en), .wr_data(wr_data), .out_rd_en(out_rd_en), .data_out(data_out),
    .data_out_vld(data_out_vld), .reg_en(reg_en), .a_reg(a_reg), .d_reg(d_reg), .wrt(wrt),
    .a_cim(a_cim), .clkm(clkm), .err_ovf(err_ovf), .err_unf(err_unf), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned wcnt = 0;
  int unsigned vcnt = 0;
  bit          armed = 0;

  // expected values for the next sampled cycle
  logic [15:0] e_in_wr = '0;
  logic [3:0]  e_out_rd = '0;
  logic        e_reg_en = 0, e_wrt = 0, e_clkm = 0;
  logic [3:0]  e_a_reg = '0;
  logic [8:0]  e_a_cim = '0;
  logic [35:0] e_d = '0;
  logic        e_ovf = 0, e_unf = 0, e_addr = 0;
  logic [2:0]  vpipe = '0;
  int unsigned ccnt = 0;
  localparam int unsigned HALF = 1;

  logic [51:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] fq[$];
  logic [31:0] rd_word;

  // FIFO model state: lane to drive right after the edge ending the out_rd_en cycle
  bit          pend = 0;
  int unsigned plane = 0;
  logic [31:0] pword = '0;

  always @(posedge clk) begin
    #1;
    if (pend)
      for (int k = 0; k < 4; k++) rd_data_bus[k*32 +: 32] = (k == int'(plane)) ? pword : ~pword;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [51:0] we;
    chk("in_wr_en", 64'(in_wr_en), 64'(e_in_wr));
    chk("out_rd_en", 64'(out_rd_en), 64'(e_out_rd));
    chk("reg_en", 64'(reg_en), 64'(e_reg_en));
    chk("a_reg", 64'(a_reg), 64'(e_a_reg));
    chk("wrt", 64'(wrt), 64'(e_wrt));
    if (e_wrt) chk("a_cim", 64'(a_cim), 64'(e_a_cim));
    if (e_reg_en) chk("d_reg", 64'(d_reg), 64'(e_d[31:0]));
    chk("err_ovf", 64'(err_ovf), 64'(e_ovf));
    chk("err_unf", 64'(err_unf), 64'(e_unf));
    chk("err_addr", 64'(err_addr), 64'(e_addr));
    chk("clkm", 64'(clkm), 64'(e_clkm));
    chk("vld", 64'(data_out_vld), 64'(vpipe[2]));
    if (in_wr_en != 0) begin
      wcnt++;
      if (wq.size() == 0) chk("wr_extra", 64'(in_wr_en), 64'd0);
      else begin
        we = wq.pop_front();
        chk("wr_ch", 64'(in_wr_en), 64'(we[51:36]));
        chk("wr_data", 64'(wr_data), 64'(we[35:0]));
      end
    end
    if (data_out_vld === 1'b1) begin
      vcnt++;
      if (rq.size() == 0) chk("rd_extra", 64'(data_out_vld), 64'd0);
      else chk("data_out", 64'(data_out), 64'(rq.pop_front()));
    end
  endtask

  task automatic step(input logic av, input logic [13:0] a, input logic [35:0] d,
                      input logic [15:0] fl, input logic [3:0] em, input logic clr, input logic r);
    logic [2:0]  op;
    int unsigned ic, oc;
    logic        nov, nuf, nad, rdi;
    logic [31:0] w;
    @(negedge clk);
    if (armed) monitor();
    armed = 1;
    pend = (out_rd_en !== 4'b0) && !$isunknown(out_rd_en);
    if (pend) begin
      for (int k = 0; k < 4; k++) if (out_rd_en[k]) plane = k;
      pword = (fq.size() != 0) ? fq.pop_front() : 32'h0;
    end
    addr_valid = av; a_in = a; data_in = d; full_in = fl; empty_out = em; err_clr = clr; rst = r;
    e_in_wr = '0; e_out_rd = '0; e_reg_en = 0; e_a_reg = '0; e_wrt = 0;
    nov = 0; nuf = 0; nad = 0; rdi = 0;
    if (r) begin
      e_ovf = 0; e_unf = 0; e_addr = 0; vpipe = '0; e_clkm = 0; ccnt = 0;
      wq.delete(); rq.delete(); fq.delete();
    end else begin
      op = a[9:7]; ic = a[3:0]; oc = a[5:4];
      if (av && a[13:10] == 4'h0) begin
        e_a_cim = a[8:0]; e_d = d;
        if (op == 3'd5 || op == 3'd6) nad = 1;
        else if (op == 3'd1) e_wrt = 1;
        else if (op == 3'd3) begin e_reg_en = 1; e_a_reg = a[3:0]; end
        else if (op == 3'd2 || op == 3'd4 || op == 3'd7) begin
          if (op != 3'd4) begin
            if (fl[ic]) nov = 1;
            else begin e_in_wr[ic] = 1'b1; wq.push_back({16'(1 << ic), d}); end
          end
          if (op != 3'd2) begin
            if (em[oc]) nuf = 1;
            else begin
              e_out_rd[oc] = 1'b1; rdi = 1;
              w = rd_word; rd_word = $urandom;
              rq.push_back(w); fq.push_back(w);
            end
          end
        end
      end
      e_ovf = (e_ovf & ~clr) | nov;
      e_unf = (e_unf & ~clr) | nuf;
      e_addr = (e_addr & ~clr) | nad;
      vpipe = {vpipe[1:0], rdi};
      if (ccnt == HALF - 1) begin ccnt = 0; e_clkm = ~e_clkm; end
      else ccnt++;
    end
  endtask

  function automatic logic [13:0] mk(input logic [3:0] c, input logic [2:0] o, input logic [6:0] b);
    return {c, o, b};
  endfunction

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    int unsigned bw, bv;
    rd_word = $urandom;
    // reset held two cycles, then free-running idle
    step(0, '0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);
    idle(4);
    // basic write, read, register write, CIM write
    step(1, mk(4'h0, 3'b010, 7'd5), 36'h9_ABCD_1234, '0, '0, 0, 0);
    rd_word = 32'hDEADBEEF;
    step(1, mk(4'h0, 3'b100, 7'h20), '0, '0, '0, 0, 0);
    idle(4);
    step(1, mk(4'h0, 3'b011, 7'h0A), 36'h5_1234_5678, '0, '0, 0, 0);
    step(1, mk(4'h0, 3'b001, 7'h55), 36'h0_0000_00AA, '0, '0, 0, 0);
    // gating and sticky errors
    step(1, mk(4'h0, 3'b010, 7'd3), 36'h1, 16'h0008, '0, 0, 0);
    idle(2);
    step(1, mk(4'h0, 3'b100, 7'h10), '0, '0, 4'b0010, 1, 0);
    idle(2);
    step(1, mk(4'h0, 3'b010, 7'd3), 36'h2, 16'h0008, '0, 1, 0);
    step(0, '0, '0, '0, '0, 1, 0);
    // chip mismatch is ignored; reserved ops flag an address error
    step(1, mk(4'h1, 3'b010, 7'd1), 36'h3, '0, '0, 0, 0);
    step(1, mk(4'h1, 3'b101, 7'd1), 36'h3, '0, '0, 0, 0);
    step(1, mk(4'h0, 3'b101, 7'd0), 36'h4, '0, '0, 0, 0);
    step(1, mk(4'h0, 3'b110, 7'd0), 36'h4, '0, '0, 0, 0);
    step(0, '0, '0, '0, '0, 1, 0);
    idle(2);
    // combined op every cycle, then a read cut short by reset
    bw = wcnt; bv = vcnt;
    for (int unsigned i = 0; i < 8; i++)
      step(1, mk(4'h0, 3'b111, 7'((i % 4) << 4 | (i + 8))), {4'h7, 32'($urandom)}, '0, '0, 0, 0);
    idle(2);
    step(1, mk(4'h0, 3'b100, 7'h00), '0, '0, '0, 0, 0);
    step(0, '0, '0, '0, '0, 0, 1);
    idle(4);
    chk("stress_writes", 64'(wcnt - bw), 64'd8);
    chk("stress_vld", 64'(vcnt - bv), 64'd8);
    // randomised traffic
    for (int unsigned i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0,
           mk(($urandom_range(0, 7) == 0) ? 4'h1 : 4'h0, 3'($urandom_range(0, 7)), 7'($urandom)),
           {4'($urandom), 32'($urandom)}, 16'($urandom & $urandom), 4'($urandom & $urandom),
           $urandom_range(0, 7) == 0, 0);
    idle(5);
    chk("wr_q_drained", 64'(wq.size()), 64'd0);
    chk("rd_q_drained", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
